// File: rtl/dna_max_collector.sv
// rtl/dna_max_collector.sv - best-score/(row,col) tracker on the DNA_PE cell-score stream
// Optional threshold hit counter built when DNA_MAX_THRESH_EN is defined.
module dna_max_collector #(
    parameter int SCORE_W = 32,
    parameter int ROW_W   = 8,
    parameter int COL_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [ROW_W-1:0]   n_rows_i,
    input  logic [COL_W-1:0]   n_cols_i,
    input  logic               cell_valid_i,
    input  logic [SCORE_W-1:0] cell_score_i,
    output logic               busy_o,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [SCORE_W-1:0] max_score_o,
    output logic [ROW_W-1:0]   max_row_o,
    output logic [COL_W-1:0]   max_col_o,
`ifdef DNA_MAX_THRESH_EN
    input  logic [SCORE_W-1:0]     thresh_i,
    output logic [ROW_W+COL_W-1:0] hit_cnt_o,
`endif
    output logic               err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   n_rows_q, n_rows_d;
    logic [COL_W-1:0]   n_cols_q, n_cols_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [SCORE_W-1:0] max_score_q, max_score_d;
    logic [ROW_W-1:0]   max_row_q, max_row_d;
    logic [COL_W-1:0]   max_col_q, max_col_d;
    logic               err_q, err_d;

    logic row_last;
    logic col_last;
    logic first_cell;
    logic take_cell;

`ifdef DNA_MAX_THRESH_EN
    localparam int HIT_W = ROW_W + COL_W;
    logic [SCORE_W-1:0] thresh_q, thresh_d;
    logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;
`endif

    assign row_last   = (row_q == n_rows_q - ROW_W'(1));
    assign col_last   = (col_q == n_cols_q - COL_W'(1));
    // Tracker is cleared to 0/0/0 at start, so cell (0,0) is the first of the job.
    assign first_cell = (row_q == '0) && (col_q == '0);
    assign take_cell  = first_cell || (cell_score_i > max_score_q);

    always_comb begin
        state_d     = state_q;
        n_rows_d    = n_rows_q;
        n_cols_d    = n_cols_q;
        row_d       = row_q;
        col_d       = col_q;
        max_score_d = max_score_q;
        max_row_d   = max_row_q;
        max_col_d   = max_col_q;
        err_d       = err_q;
`ifdef DNA_MAX_THRESH_EN
        thresh_d    = thresh_q;
        hit_cnt_d   = hit_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    // A cell arriving with start is dropped silently.
                    n_rows_d    = n_rows_i;
                    n_cols_d    = n_cols_i;
                    row_d       = '0;
                    col_d       = '0;
                    max_score_d = '0;
                    max_row_d   = '0;
                    max_col_d   = '0;
                    err_d       = 1'b0;
`ifdef DNA_MAX_THRESH_EN
                    thresh_d    = thresh_i;
                    hit_cnt_d   = '0;
`endif
                    if ((n_rows_i == '0) || (n_cols_i == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACCUM;
                    end
                end else if (cell_valid_i) begin
                    err_d = 1'b1;
                end
            end
            ACCUM: begin
                if (cell_valid_i) begin
                    if (take_cell) begin
                        max_score_d = cell_score_i;
                        max_row_d   = row_q;
                        max_col_d   = col_q;
                    end
`ifdef DNA_MAX_THRESH_EN
                    if ((cell_score_i >= thresh_q) && (hit_cnt_q != {HIT_W{1'b1}})) begin
                        hit_cnt_d = hit_cnt_q + HIT_W'(1);
                    end
`endif
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            row_d   = '0;
                            state_d = DONE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DONE: begin
                if (cell_valid_i) begin
                    err_d = 1'b1;
                end
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            n_rows_q    <= '0;
            n_cols_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            max_score_q <= '0;
            max_row_q   <= '0;
            max_col_q   <= '0;
            err_q       <= 1'b0;
`ifdef DNA_MAX_THRESH_EN
            thresh_q    <= '0;
            hit_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_rows_q    <= n_rows_d;
            n_cols_q    <= n_cols_d;
            row_q       <= row_d;
            col_q       <= col_d;
            max_score_q <= max_score_d;
            max_row_q   <= max_row_d;
            max_col_q   <= max_col_d;
            err_q       <= err_d;
`ifdef DNA_MAX_THRESH_EN
            thresh_q    <= thresh_d;
            hit_cnt_q   <= hit_cnt_d;
`endif
        end
    end

    assign busy_o      = (state_q == ACCUM);
    assign res_valid_o = (state_q == DONE);
    assign max_score_o = max_score_q;
    assign max_row_o   = max_row_q;
    assign max_col_o   = max_col_q;
    assign err_o       = err_q;
`ifdef DNA_MAX_THRESH_EN
    assign hit_cnt_o   = hit_cnt_q;
`endif

endmodule

// File: tb/tb_dna_max_collector.sv
// tb/tb_dna_max_collector.sv - bench for dna_max_collector against a row-major argmax model
module tb_dna_max_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [7:0]  n_rows_i;
    logic [7:0]  n_cols_i;
    logic        cell_valid_i;
    logic [31:0] cell_score_i;
    logic        busy_o;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] max_score_o;
    logic [7:0]  max_row_o;
    logic [7:0]  max_col_o;
    logic        err_o;
`ifdef DNA_MAX_THRESH_EN
    logic [31:0] thresh_i;
    logic [15:0] hit_cnt_o;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dna_max_collector dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .n_rows_i     (n_rows_i),
        .n_cols_i     (n_cols_i),
        .cell_valid_i (cell_valid_i),
        .cell_score_i (cell_score_i),
        .busy_o       (busy_o),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .max_score_o  (max_score_o),
        .max_row_o    (max_row_o),
        .max_col_o    (max_col_o),
`ifdef DNA_MAX_THRESH_EN
        .thresh_i     (thresh_i),
        .hit_cnt_o    (hit_cnt_o),
`endif
        .err_o        (err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_score;
    int          exp_row;
    int          exp_col;
    int          exp_hits;

    // Start a job, stream its cells with random gaps, and check the result against the model.
    task automatic feed_job(input int rows, input int cols, input logic [31:0] sc[$],
                            input logic [31:0] th, input int max_gap, input bit junk_on_start);
        int best;
        n_rows_i = 8'(rows);
        n_cols_i = 8'(cols);
`ifdef DNA_MAX_THRESH_EN
        thresh_i = th;
`endif
        start_i = 1'b1;
        if (junk_on_start) begin
            cell_valid_i = 1'b1;
            cell_score_i = 32'hFFFF_FFFF;
        end
        tick();
        start_i      = 1'b0;
        cell_valid_i = 1'b0;
        check("err_cleared_by_start", err_o, 0);
        check("busy_after_start", busy_o, (rows != 0 && cols != 0));
        for (int i = 0; i < sc.size(); i++) begin
            int gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) tick();
            if (i == sc.size() - 1) check("no_valid_before_last", res_valid_o, 0);
            cell_valid_i = 1'b1;
            cell_score_i = sc[i];
            tick();
            cell_valid_i = 1'b0;
        end
        best     = 0;
        exp_hits = 0;
        for (int i = 0; i < sc.size(); i++) begin
            if (sc[i] > sc[best]) best = i;
            if (sc[i] >= th) exp_hits++;
        end
        if (exp_hits > 65535) exp_hits = 65535;
        exp_score = (sc.size() == 0) ? 32'd0 : sc[best];
        exp_row   = (sc.size() == 0) ? 0 : best / cols;
        exp_col   = (sc.size() == 0) ? 0 : best % cols;
        check("res_valid", res_valid_o, 1);
        check("busy_in_done", busy_o, 0);
        check("max_score", max_score_o, exp_score);
        check("max_row", max_row_o, exp_row);
        check("max_col", max_col_o, exp_col);
`ifdef DNA_MAX_THRESH_EN
        check("hit_cnt", hit_cnt_o, exp_hits);
`endif
    endtask

    task automatic accept_result(input int hold);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("held_valid", res_valid_o, 1);
            check("held_score", max_score_o, exp_score);
            check("held_row", max_row_o, exp_row);
            check("held_col", max_col_o, exp_col);
        end
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        check("valid_drop_on_accept", res_valid_o, 0);
    endtask

    initial begin
        logic [31:0] q[$];
        int r, c;

        rst          = 1'b1;
        start_i      = 1'b0;
        n_rows_i     = '0;
        n_cols_i     = '0;
        cell_valid_i = 1'b0;
        cell_score_i = '0;
        res_ready_i  = 1'b0;
`ifdef DNA_MAX_THRESH_EN
        thresh_i     = '0;
`endif
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy_o, 0);
        check("rst_valid", res_valid_o, 0);
        check("rst_score", max_score_o, 0);
        check("rst_row", max_row_o, 0);
        check("rst_col", max_col_o, 0);
        check("rst_err", err_o, 0);

        // 2x3 job back to back, threshold 5
        q = '{32'd1, 32'd5, 32'd2, 32'd0, 32'd7, 32'd3};
        feed_job(2, 3, q, 32'd5, 0, 1'b0);
        check("spec_2x3_score", max_score_o, 7);
        check("spec_2x3_row", max_row_o, 1);
        check("spec_2x3_col", max_col_o, 1);
        accept_result(0);

        // earliest of tied maxima wins
        q = '{32'd4, 32'd9, 32'd9, 32'd1};
        feed_job(2, 2, q, 32'd5, 1, 1'b0);
        check("tie_row", max_row_o, 0);
        check("tie_col", max_col_o, 1);
        accept_result(0);

        // DONE ignores start, flags stray cell, holds result under back-pressure
        q = '{32'd3, 32'd8};
        feed_job(1, 2, q, 32'd0, 0, 1'b0);
        start_i      = 1'b1;
        cell_valid_i = 1'b1;
        cell_score_i = 32'hFFFF_FFFF;
        n_rows_i     = 8'd0;
        tick();
        start_i      = 1'b0;
        cell_valid_i = 1'b0;
        check("done_err_set", err_o, 1);
        check("done_no_restart", res_valid_o, 1);
        accept_result(5);
        check("err_sticky", err_o, 1);

        // first-cell score 0 must still load its coordinates
        q = '{32'd0};
        feed_job(1, 1, q, 32'd0, 0, 1'b0);
        accept_result(1);

        // stray cell in IDLE sets err; start with a cell in the same cycle drops it quietly
        cell_valid_i = 1'b1;
        cell_score_i = 32'd77;
        tick();
        cell_valid_i = 1'b0;
        check("idle_err_set", err_o, 1);
        q = '{32'd2, 32'd6, 32'd6};
        feed_job(3, 1, q, 32'd6, 2, 1'b1);
        accept_result(2);

        // zero dimensions go straight to DONE with 0/0/0
        q = {};
        feed_job(0, 4, q, 32'd0, 0, 1'b0);
        accept_result(1);
        feed_job(3, 0, q, 32'd0, 0, 1'b0);
        accept_result(0);

        // reset mid-job discards everything
        n_rows_i = 8'd2;
        n_cols_i = 8'd3;
        start_i  = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cell_valid_i = 1'b1;
            cell_score_i = 32'(40 + i);
            tick();
        end
        cell_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_valid", res_valid_o, 0);
        check("abort_score", max_score_o, 0);
        check("abort_row", max_row_o, 0);
        check("abort_col", max_col_o, 0);
        q = '{32'd12};
        feed_job(1, 1, q, 32'd0, 0, 1'b0);
        check("fresh_1x1_score", max_score_o, 12);
        accept_result(0);

        // randomized jobs; small score range makes ties common
        for (int j = 0; j < 12; j++) begin
            r = $urandom_range(1, 6);
            c = $urandom_range(1, 6);
            q = {};
            for (int k = 0; k < r * c; k++) q.push_back(32'($urandom_range(0, 15)));
            if (j == 11) q[0] = 32'hFFFF_FFFF;
            feed_job(r, c, q, 32'($urandom_range(0, 15)), j % 3, 1'b0);
            accept_result($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
